io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra cycles between request capture and Ready_H (legal range 0..7).
REQ-002 Parameter TIMER_WIDTH, default 32: width of timer load/count registers.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Address  input  32  byte address from CPU bus.
REQ-006 IO_Select_H  input  1  high when Address is in 0x04000000-0x0400FFFF (from address decoder).
REQ-007 Read_H  input  1  read request.
REQ-008 Write_H  input  1  write request.
REQ-009 WriteData  input  32  write data.
REQ-010 ByteEnable  input  4  per-byte write strobes.
REQ-011 ReadData  output  32  read data, valid when Ready_H is high.
REQ-012 Ready_H  output  1  one-cycle completion pulse.
REQ-013 SW  input  10  board switches, asynchronous to clk.
REQ-014 LEDR  output  10  LED register.
REQ-015 HEX  output  24  six 4-bit hex digits.
REQ-016 Timer_IRQ_H  output  1  level interrupt: timer expired AND irq enabled.

Function
REQ-017 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-018 IDLE -> WAIT (or RESP if WAIT_STATES=0) when IO_Select_H && (Read_H || Write_H); latch Address[15:0], Write_H, WriteData, ByteEnable.
REQ-019 WAIT counts WAIT_STATES cycles, then -> RESP.
REQ-020 RESP: Ready_H=1 for exactly one cycle, write committed in this cycle, ReadData driven; -> IDLE.
REQ-021 Minimum request-to-Ready_H latency = WAIT_STATES+1 cycles; back-to-back accesses need one IDLE cycle between them.
REQ-022 Read_H and Write_H both high: treated as write.
REQ-023 Bus inputs changing after capture are ignored until return to IDLE.
REQ-024 Register map (offset = Address[15:0], word aligned, Address[1:0] ignored): 0x00 LEDR RW[9:0]; 0x04 SW RO[9:0]; 0x08 HEX RW[23:0]; 0x10 TCTRL RW {bit0 enable, bit1 irq_en, bit2 auto_reload}; 0x14 TLOAD RW; 0x18 TCOUNT RO; 0x1C TSTAT bit0 expired, write-1-to-clear.
REQ-025 Unmapped offsets: read 0, write ignored, Ready_H still asserted.
REQ-026 Unused upper read bits return 0.
REQ-027 Byte lanes written only where ByteEnable bit set.
REQ-028 SW passes through a 2-flop synchronizer; reads return synchronized value.
REQ-029 Timer: when enable and count!=0, count decrements by 1 per clk.
REQ-030 On count transition 1->0: expired set; if auto_reload, count<=TLOAD next cycle, else stays 0.
REQ-031 Write to TLOAD also loads TCOUNT in the same cycle; takes priority over decrement.
REQ-032 Expiry and TSTAT W1C in same cycle: expired stays set (set wins).
REQ-033 Timer_IRQ_H = expired && irq_en, registered-free combinational from flops.
REQ-034 Writing enable=0 freezes count; re-enable resumes from held value.

Reset
REQ-035 reset (synchronous) forces IDLE, Ready_H=0, ReadData=0, LEDR=0, HEX=0, TCTRL=0, TLOAD=0, TCOUNT=0, expired=0, Timer_IRQ_H=0, synchronizer flops=0.
REQ-036 reset during WAIT/RESP aborts access: no Ready_H, no register write.

Structure
REQ-037 Package io_pkg holds register offset constants, TCTRL bit indices and the FSM state enum.
REQ-038 Timer (count, reload, expired, W1C) in one sub-module io_timer; io_responder instantiates it.

Verification
REQ-039 Write 0x3FF to 0x04000000, ByteEnable=0xF, WAIT_STATES=1 -> Ready_H at cycle 2 after request; LEDR=0x3FF.
REQ-040 SW=0x155 held, read 0x04000004 -> ReadData=0x00000155 with Ready_H.
REQ-041 TLOAD=5, TCTRL=0x7 -> expired set 5 cycles after enable, Timer_IRQ_H=1, TCOUNT reloads 5; W1C 0x1 to 0x1C clears IRQ.
REQ-042 Read 0x04000020 -> ReadData=0, Ready_H pulses once; write to 0x04000020 changes no register.
REQ-043 Write HEX 0xABCDEF with ByteEnable=0x2 over prior 0 -> HEX=0x00CD00.
REQ-044 Assert reset in WAIT of a write of 0x3 to LEDR -> no Ready_H, LEDR=0, FSM IDLE.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO responder: register offsets,
// timer control bit positions, bus FSM states and a byte-lane merge helper.
package io_pkg;

    localparam logic [15:0] OFF_LEDR   = 16'h0000;
    localparam logic [15:0] OFF_SW     = 16'h0004;
    localparam logic [15:0] OFF_HEX    = 16'h0008;
    localparam logic [15:0] OFF_TCTRL  = 16'h0010;
    localparam logic [15:0] OFF_TLOAD  = 16'h0014;
    localparam logic [15:0] OFF_TCOUNT = 16'h0018;
    localparam logic [15:0] OFF_TSTAT  = 16'h001C;

    localparam int TCTRL_ENABLE      = 0;
    localparam int TCTRL_IRQ_EN      = 1;
    localparam int TCTRL_AUTO_RELOAD = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } io_state_e;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/io_timer.sv
// Down-counting interval timer with optional auto-reload, a sticky expired
// flag (write-1-to-clear, set wins) and a gated level interrupt.
module io_timer #(
    parameter int TIMER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctrl_we,
    input  logic [2:0]             ctrl_wdata,
    input  logic                   load_we,
    input  logic [TIMER_WIDTH-1:0] load_wdata,
    input  logic                   stat_clr,
    output logic [2:0]             ctrl,
    output logic [TIMER_WIDTH-1:0] load,
    output logic [TIMER_WIDTH-1:0] count,
    output logic                   expired,
    output logic                   irq
);
    import io_pkg::*;

    localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

    logic [2:0]             ctrl_q,    ctrl_d;
    logic [TIMER_WIDTH-1:0] load_q,    load_d;
    logic [TIMER_WIDTH-1:0] count_q,   count_d;
    logic                   expired_q, expired_d;
    logic                   expire_evt;

    // A TLOAD write overrides counting; a zero count reloads one cycle after expiry.
    always_comb begin
        ctrl_d     = ctrl_we ? ctrl_wdata : ctrl_q;
        load_d     = load_we ? load_wdata : load_q;
        count_d    = count_q;
        expire_evt = 1'b0;
        if (load_we) begin
            count_d = load_wdata;
        end else if (ctrl_q[TCTRL_ENABLE]) begin
            if (count_q != '0) begin
                count_d    = count_q - ONE;
                expire_evt = (count_q == ONE);
            end else if (ctrl_q[TCTRL_AUTO_RELOAD]) begin
                count_d = load_q;
            end
        end
        if (expire_evt) begin
            expired_d = 1'b1;
        end else if (stat_clr) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign ctrl    = ctrl_q;
    assign load    = load_q;
    assign count   = count_q;
    assign expired = expired_q;
    assign irq     = expired_q && ctrl_q[TCTRL_IRQ_EN];

endmodule

// File: rtl/io_responder.sv
// CPU bus slave for the board IO block: LEDs, switches, hex display and timer,
// answering each captured request with a one-cycle Ready_H after WAIT_STATES.
module io_responder #(
    parameter int WAIT_STATES = 1,
    parameter int TIMER_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        IO_Select_H,
    input  logic        Read_H,
    input  logic        Write_H,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEnable,
    output logic [31:0] ReadData,
    output logic        Ready_H,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [23:0] HEX,
    output logic        Timer_IRQ_H
);
    import io_pkg::*;

    io_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [13:0] off_q, off_d;
    logic        is_write_q, is_write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [23:0] hex_q, hex_d;
    logic [9:0]  sw_meta_q, sw_sync_q;

    logic                   req;
    logic                   commit;
    logic                   next_is_write;
    logic [13:0]            rd_off;
    logic [31:0]            rd_val;
    logic [2:0]             tmr_ctrl;
    logic [TIMER_WIDTH-1:0] tmr_load;
    logic [TIMER_WIDTH-1:0] tmr_count;
    logic                   tmr_expired;
    logic                   tmr_irq;
    logic                   unused_addr;

    assign unused_addr = ^{Address[31:16], Address[1:0]};

    assign req    = IO_Select_H && (Read_H || Write_H);
    assign commit = (state_q == RESP) && is_write_q;

    // Read data is sampled as the FSM enters RESP, so in IDLE look at the live address.
    assign rd_off        = (state_q == IDLE) ? Address[15:2] : off_q;
    assign next_is_write = (state_q == IDLE) ? Write_H : is_write_q;

    always_comb begin
        case ({rd_off, 2'b00})
            OFF_LEDR:   rd_val = {22'b0, ledr_q};
            OFF_SW:     rd_val = {22'b0, sw_sync_q};
            OFF_HEX:    rd_val = {8'b0, hex_q};
            OFF_TCTRL:  rd_val = {29'b0, tmr_ctrl};
            OFF_TLOAD:  rd_val = 32'(tmr_load);
            OFF_TCOUNT: rd_val = 32'(tmr_count);
            OFF_TSTAT:  rd_val = {31'b0, tmr_expired};
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        is_write_d = is_write_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    off_d      = Address[15:2];
                    is_write_d = Write_H;
                    wdata_d    = WriteData;
                    be_d       = ByteEnable;
                    cnt_d      = 3'd0;
                    state_d    = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'(WAIT_STATES - 1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == RESP);
        rdata_d = (state_d == RESP && state_q != RESP && !next_is_write) ? rd_val : '0;
    end

    always_comb begin
        ledr_d = ledr_q;
        hex_d  = hex_q;
        if (commit && {off_q, 2'b00} == OFF_LEDR) begin
            ledr_d = 10'(merge_bytes({22'b0, ledr_q}, wdata_q, be_q));
        end
        if (commit && {off_q, 2'b00} == OFF_HEX) begin
            hex_d = 24'(merge_bytes({8'b0, hex_q}, wdata_q, be_q));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            off_q      <= '0;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            ledr_q     <= '0;
            hex_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            is_write_q <= is_write_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            ledr_q     <= ledr_d;
            hex_q      <= hex_d;
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
        end
    end

    io_timer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .ctrl_we    (commit && {off_q, 2'b00} == OFF_TCTRL),
        .ctrl_wdata (3'(merge_bytes({29'b0, tmr_ctrl}, wdata_q, be_q))),
        .load_we    (commit && {off_q, 2'b00} == OFF_TLOAD),
        .load_wdata (TIMER_WIDTH'(merge_bytes(32'(tmr_load), wdata_q, be_q))),
        .stat_clr   (commit && {off_q, 2'b00} == OFF_TSTAT && be_q[0] && wdata_q[0]),
        .ctrl       (tmr_ctrl),
        .load       (tmr_load),
        .count      (tmr_count),
        .expired    (tmr_expired),
        .irq        (tmr_irq)
    );

    assign ReadData    = rdata_q;
    assign Ready_H     = ready_q;
    assign LEDR        = ledr_q;
    assign HEX         = hex_q;
    assign Timer_IRQ_H = tmr_irq;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder (WAIT_STATES=1): bus accesses, register map,
// byte lanes, timer expiry/reload/W1C and reset abort of a pending write.
module tb_io_responder;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic        IO_Select_H;
   logic        Read_H;
   logic        Write_H;
   logic [31:0] WriteData;
   logic [3:0]  ByteEnable;
   logic [31:0] ReadData;
   logic        Ready_H;
   logic [9:0]  SW;
   logic [9:0]  LEDR;
   logic [23:0] HEX;
   logic        Timer_IRQ_H;

   int compareCount = 0;
   int failCount    = 0;

   io_responder #(
      .WAIT_STATES(1),
      .TIMER_WIDTH(32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Address    (Address),
      .IO_Select_H(IO_Select_H),
      .Read_H     (Read_H),
      .Write_H    (Write_H),
      .WriteData  (WriteData),
      .ByteEnable (ByteEnable),
      .ReadData   (ReadData),
      .Ready_H    (Ready_H),
      .SW         (SW),
      .LEDR       (LEDR),
      .HEX        (HEX),
      .Timer_IRQ_H(Timer_IRQ_H)
   );

   // Free-running 10 ns clock; inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Issue one bus access, scramble the bus right after capture, wait for Ready_H
   // (bounded), and confirm the ready pulse lasts exactly one cycle.
   task automatic applyStimulus(input logic wr, input logic both, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rdata, output int lat);
      int n;
      IO_Select_H = (addr[31:16] == 16'h0400);
      Address     = addr;
      Write_H     = wr;
      Read_H      = !wr || both;
      WriteData   = wdata;
      ByteEnable  = be;
      @(negedge clk);
      IO_Select_H = 1'b0;
      Read_H      = 1'b0;
      Write_H     = 1'b0;
      Address     = 32'h0400_FFFC;
      WriteData   = 32'h5A5A_5A5A;
      ByteEnable  = 4'hF;
      n     = 1;
      lat   = -1;
      rdata = '0;
      while (n <= 16 && lat < 0) begin
         if (Ready_H) begin
            lat   = n;
            rdata = ReadData;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      checkOutput("readyOnePulse", {31'b0, Ready_H}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      int          readySeen;

      reset       = 1'b1;
      Address     = '0;
      IO_Select_H = 1'b0;
      Read_H      = 1'b0;
      Write_H     = 1'b0;
      WriteData   = '0;
      ByteEnable  = '0;
      SW          = 10'h155;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("resetReady", {31'b0, Ready_H}, 32'd0);
      checkOutput("resetReadData", ReadData, 32'd0);
      checkOutput("resetLedr", {22'b0, LEDR}, 32'd0);
      checkOutput("resetHex", {8'b0, HEX}, 32'd0);
      checkOutput("resetIrq", {31'b0, Timer_IRQ_H}, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'h0400_0000, 32'h0000_03FF, 4'hF, rd, lat);
      checkOutput("ledrWriteLatency", 32'(lat), 32'd2);
      checkOutput("ledrWrite", {22'b0, LEDR}, 32'h3FF);

      applyStimulus(1'b0, 1'b0, 32'h0400_0004, '0, 4'h0, rd, lat);
      checkOutput("swReadLatency", 32'(lat), 32'd2);
      checkOutput("swRead", rd, 32'h0000_0155);

      applyStimulus(1'b0, 1'b0, 32'h0400_0000, '0, 4'h0, rd, lat);
      checkOutput("ledrRead", rd, 32'h0000_03FF);

      applyStimulus(1'b1, 1'b0, 32'h0400_0008, 32'h00AB_CDEF, 4'h2, rd, lat);
      checkOutput("hexLaneWrite", {8'b0, HEX}, 32'h0000_CD00);
      applyStimulus(1'b0, 1'b0, 32'h0400_0008, '0, 4'h0, rd, lat);
      checkOutput("hexRead", rd, 32'h0000_CD00);

      applyStimulus(1'b0, 1'b0, 32'h0400_0020, '0, 4'h0, rd, lat);
      checkOutput("unmappedReadLatency", 32'(lat), 32'd2);
      checkOutput("unmappedRead", rd, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0400_0020, 32'hFFFF_FFFF, 4'hF, rd, lat);
      checkOutput("unmappedWriteLatency", 32'(lat), 32'd2);
      checkOutput("unmappedWriteLedr", {22'b0, LEDR}, 32'h3FF);
      checkOutput("unmappedWriteHex", {8'b0, HEX}, 32'h0000_CD00);

      applyStimulus(1'b1, 1'b0, 32'h0400_0000, 32'h0000_0000, 4'h1, rd, lat);
      checkOutput("ledrLowLaneOnly", {22'b0, LEDR}, 32'h300);

      applyStimulus(1'b1, 1'b1, 32'h0400_0000, 32'h0000_00AA, 4'hF, rd, lat);
      checkOutput("readWriteAsWrite", {22'b0, LEDR}, 32'h0AA);

      applyStimulus(1'b1, 1'b0, 32'h0400_0014, 32'd5, 4'hF, rd, lat);
      applyStimulus(1'b0, 1'b0, 32'h0400_0018, '0, 4'h0, rd, lat);
      checkOutput("tloadLoadsCount", rd, 32'd5);
      applyStimulus(1'b1, 1'b0, 32'h0400_0010, 32'h7, 4'hF, rd, lat);
      repeat (4) @(negedge clk);
      checkOutput("irqBeforeExpiry", {31'b0, Timer_IRQ_H}, 32'd0);
      @(negedge clk);
      checkOutput("irqAtExpiry", {31'b0, Timer_IRQ_H}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0400_0018, '0, 4'h0, rd, lat);
      checkOutput("autoReloadCount", rd, 32'd5);
      checkOutput("irqHeld", {31'b0, Timer_IRQ_H}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0400_0010, 32'h6, 4'hF, rd, lat);
      applyStimulus(1'b1, 1'b0, 32'h0400_001C, 32'h1, 4'hF, rd, lat);
      checkOutput("irqW1cCleared", {31'b0, Timer_IRQ_H}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0400_0018, '0, 4'h0, rd, lat);
      checkOutput("countFrozen", rd, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'h0400_0014, 32'd3, 4'hF, rd, lat);
      applyStimulus(1'b1, 1'b0, 32'h0400_0010, 32'h1, 4'hF, rd, lat);
      repeat (3) @(negedge clk);
      checkOutput("irqGatedOff", {31'b0, Timer_IRQ_H}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0400_001C, '0, 4'h0, rd, lat);
      checkOutput("tstatExpired", rd, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0400_0018, '0, 4'h0, rd, lat);
      checkOutput("noReloadStaysZero", rd, 32'd0);

      IO_Select_H = 1'b1;
      Address     = 32'h0400_0000;
      Write_H     = 1'b1;
      Read_H      = 1'b0;
      WriteData   = 32'h3;
      ByteEnable  = 4'hF;
      @(negedge clk);
      reset       = 1'b1;
      IO_Select_H = 1'b0;
      Write_H     = 1'b0;
      @(negedge clk);
      checkOutput("abortReady", {31'b0, Ready_H}, 32'd0);
      checkOutput("abortLedr", {22'b0, LEDR}, 32'd0);
      reset     = 1'b0;
      readySeen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (Ready_H) readySeen++;
      end
      checkOutput("abortNoLateReady", 32'(readySeen), 32'd0);
      checkOutput("abortLedrAfter", {22'b0, LEDR}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0400_0000, '0, 4'h0, rd, lat);
      checkOutput("idleAfterAbortLatency", 32'(lat), 32'd2);
      checkOutput("idleAfterAbortRead", rd, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
